// File: rtl/e203_clk_ctrl_mc_pkg.sv
// ----------------------------------------------------------------------------
// e203_clk_ctrl_mc_pkg
//   Shared types for the multi-channel clock-gating controller.
//   - cg_state_e : per-channel FSM state codes (RUN/HOLD/SLEEP/WAKE)
//   - cg_ctrl_t  : decoded per-channel controls {rdy, ls, en}
//   - cg_decode  : state (+ cgstop override) to control decode
// ----------------------------------------------------------------------------
package e203_clk_ctrl_mc_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_HOLD  = 2'd1,
        CG_SLEEP = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    typedef struct packed {
        logic rdy;   // clock running and memory awake
        logic ls;    // memory light-sleep request
        logic en;    // clock-gate enable (before the latch)
    } cg_ctrl_t;

    // Outputs depend only on registered state and the cgstop override, so
    // there is never a combinational path from channel activity to rdy/ls/en.
    function automatic cg_ctrl_t cg_decode(input cg_state_e st, input logic cgstop);
        cg_ctrl_t c;
        c = '{rdy: 1'b1, ls: 1'b0, en: 1'b1};
        if (!cgstop) begin
            case (st)
                CG_SLEEP: c = '{rdy: 1'b0, ls: 1'b1, en: 1'b0};
                CG_WAKE:  c = '{rdy: 1'b0, ls: 1'b0, en: 1'b0};
                default:  c = '{rdy: 1'b1, ls: 1'b0, en: 1'b1};
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/e203_clk_ctrl_mc_chnl.sv
// ----------------------------------------------------------------------------
// e203_clk_ctrl_mc_chnl
//   One gated clock channel: idle hold-off / light-sleep / wake FSM with a
//   shared down-counter, plus a latch-based clock gate.
// Ports
//   clk_i        in   core clock
//   rst_n_i      in   asynchronous active-low reset
//   test_mode_i  in   force the gate transparent (FSM unaffected)
//   cgstop_i     in   gating override: rdy=1, ls=0, en=1, FSM -> RUN
//   act_i        in   qualified channel activity
//   rdy_o        out  channel clock running and memory awake
//   ls_o         out  memory light-sleep control
//   clk_o        out  gated clock
//   sleep_o      out  channel FSM is in SLEEP
// ----------------------------------------------------------------------------
module e203_clk_ctrl_mc_chnl
    import e203_clk_ctrl_mc_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned WAKE_CYC = 1,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic test_mode_i,
    input  logic cgstop_i,
    input  logic act_i,
    output logic rdy_o,
    output logic ls_o,
    output logic clk_o,
    output logic sleep_o
);

    // Counter reload values; a zero cycle count skips the state entirely.
    localparam logic [CNT_W-1:0] HOLD_LD = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
    localparam cg_state_e        RST_ST  = (HOLD_CYC > 0) ? CG_HOLD : CG_SLEEP;

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cg_ctrl_t         ctrl;
    logic             en_lat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RST_ST;
            cnt_q   <= HOLD_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cgstop_i) begin
            state_d = CG_RUN;
        end else begin
            case (state_q)
                CG_RUN: begin
                    if (!act_i) begin
                        if (HOLD_CYC == 0) begin
                            state_d = CG_SLEEP;
                        end else begin
                            state_d = CG_HOLD;
                            cnt_d   = HOLD_LD;
                        end
                    end
                end
                CG_HOLD: begin
                    if (act_i)              state_d = CG_RUN;
                    else if (cnt_q == '0)   state_d = CG_SLEEP;
                    else                    cnt_d   = cnt_q - 1'b1;
                end
                CG_SLEEP: begin
                    if (act_i) begin
                        if (WAKE_CYC == 0) begin
                            state_d = CG_RUN;
                        end else begin
                            state_d = CG_WAKE;
                            cnt_d   = WAKE_LD;
                        end
                    end
                end
                CG_WAKE: begin
                    // Wake is not abortable; a dropped request is handled by
                    // the normal RUN -> HOLD path afterwards.
                    if (cnt_q == '0) state_d = CG_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: begin
                    state_d = RST_ST;
                    cnt_d   = HOLD_LD;
                end
            endcase
        end
    end

    assign ctrl    = cg_decode(state_q, cgstop_i);
    assign rdy_o   = ctrl.rdy;
    assign ls_o    = ctrl.ls;
    assign sleep_o = (state_q == CG_SLEEP);

    // Glitch-free gate: enable sampled while clk is low, so an en change
    // appears on the gated clock from the next high phase.
    always_latch begin
        if (!clk_i) en_lat_q <= ctrl.en | test_mode_i;
    end

    assign clk_o = clk_i & en_lat_q;

endmodule

// File: rtl/e203_clk_ctrl_mc.sv
// ----------------------------------------------------------------------------
// e203_clk_ctrl_mc
//   Parameterised multi-channel clock-gating controller. Each channel has its
//   own hold-off / light-sleep / wake FSM; the top adds the WFI qualifier and
//   the registered all-channels-asleep PMU hint.
// Ports
//   clk          in   core clock
//   rst_n        in   asynchronous active-low reset
//   test_mode    in   DFT: all gates transparent
//   core_cgstop  in   mcgstop[0]; overrides all gating
//   core_wfi     in   core in WFI
//   ch_active    in   per-channel activity/request  [CH_N]
//   ch_rdy       out  channel clock running, memory awake [CH_N]
//   ch_ls        out  memory light-sleep control [CH_N]
//   clk_ch       out  gated clocks [CH_N]
//   all_gated    out  every channel in SLEEP (registered)
//   clk_aon      out  always-on clock
// ----------------------------------------------------------------------------
module e203_clk_ctrl_mc
    import e203_clk_ctrl_mc_pkg::*;
#(
    parameter int unsigned      CH_N     = 6,
    parameter int unsigned      HOLD_CYC = 2,
    parameter int unsigned      WAKE_CYC = 1,
    parameter int unsigned      CNT_W    = 4,
    parameter logic [CH_N-1:0]  WFI_MASK = 6'b000001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            test_mode,
    input  logic            core_cgstop,
    input  logic            core_wfi,
    input  logic [CH_N-1:0] ch_active,
    output logic [CH_N-1:0] ch_rdy,
    output logic [CH_N-1:0] ch_ls,
    output logic [CH_N-1:0] clk_ch,
    output logic            all_gated,
    output logic            clk_aon
);

    logic [CH_N-1:0] eff_act;
    logic [CH_N-1:0] ch_sleep;
    logic            all_gated_q;

    // Channels flagged in WFI_MASK are treated as idle while the core waits.
    assign eff_act = ch_active & ~(WFI_MASK & {CH_N{core_wfi}});

    for (genvar i = 0; i < CH_N; i++) begin : g_ch
        e203_clk_ctrl_mc_chnl #(
            .HOLD_CYC (HOLD_CYC),
            .WAKE_CYC (WAKE_CYC),
            .CNT_W    (CNT_W)
        ) u_chnl (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .test_mode_i (test_mode),
            .cgstop_i    (core_cgstop),
            .act_i       (eff_act[i]),
            .rdy_o       (ch_rdy[i]),
            .ls_o        (ch_ls[i]),
            .clk_o       (clk_ch[i]),
            .sleep_o     (ch_sleep[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_gated_q <= 1'b0;
        else        all_gated_q <= &ch_sleep;
    end

    assign all_gated = all_gated_q;
    assign clk_aon   = clk;

endmodule

// File: tb/tb_e203_clk_ctrl_mc.sv
module tb_e203_clk_ctrl_mc;

    localparam int CH_N  = 6;
    localparam int S_RDY = 0;
    localparam int S_LS  = 1;
    localparam int S_AG  = 2;
    localparam int S_CLK = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            test_mode = 1'b0;
    logic            core_cgstop = 1'b0;
    logic            core_wfi = 1'b0;
    logic [CH_N-1:0] ch_active = '0;
    logic [CH_N-1:0] ch_rdy, ch_ls, clk_ch;
    logic            all_gated, clk_aon;

    e203_clk_ctrl_mc #(
        .CH_N(6), .HOLD_CYC(2), .WAKE_CYC(1), .CNT_W(4), .WFI_MASK(6'b000001)
    ) dut (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .core_cgstop(core_cgstop),
        .core_wfi(core_wfi), .ch_active(ch_active), .ch_rdy(ch_rdy), .ch_ls(ch_ls),
        .clk_ch(clk_ch), .all_gated(all_gated), .clk_aon(clk_aon)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         sel;
        logic [5:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Queue an expectation d sampling points from now.
    task automatic expect_at(input int d, input int sel, input logic [5:0] v, input string tag);
        exp_t e;
        e.due = cyc + d;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    function automatic logic [5:0] observe(input int sel);
        case (sel)
            S_RDY:   return ch_rdy;
            S_LS:    return ch_ls;
            S_AG:    return {5'b0, all_gated};
            default: return clk_ch;
        endcase
    endfunction

    task automatic scan();
        exp_t       keep[$];
        logic [5:0] obs;
        foreach (sb[k]) begin
            if (sb[k].due == cyc) begin
                obs = observe(sb[k].sel);
                checks++;
                assert (obs === sb[k].val) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%h expected=%h", sb[k].tag, cyc, obs, sb[k].val);
                end
            end else begin
                keep.push_back(sb[k]);
            end
        end
        sb = keep;
    endtask

    // Sample while clk is high so clk_ch shows the latched enable.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            scan();
        end
    endtask

    task automatic settle();
        #1;
        scan();
    endtask

    initial begin
        #2;
        tick();
        // reset state
        expect_at(0, S_RDY, 6'h3F, "rst_rdy");
        expect_at(0, S_LS,  6'h00, "rst_ls");
        expect_at(0, S_AG,  6'h00, "rst_ag");
        expect_at(0, S_CLK, 6'h3F, "rst_clk");
        settle();

        // idle after reset: HOLD two cycles then SLEEP
        rst_n = 1'b1;
        expect_at(1, S_RDY, 6'h3F, "hold_rdy");
        expect_at(1, S_LS,  6'h00, "hold_ls");
        expect_at(2, S_RDY, 6'h00, "slp_rdy");
        expect_at(2, S_LS,  6'h3F, "slp_ls");
        expect_at(2, S_AG,  6'h00, "slp_ag_lag");
        expect_at(2, S_CLK, 6'h3F, "slp_clk_lag");
        expect_at(3, S_AG,  6'h01, "slp_ag");
        expect_at(3, S_CLK, 6'h00, "slp_clk");
        tick(3);

        // ch2 wake from SLEEP
        ch_active = 6'h04;
        expect_at(1, S_LS,  6'h3B, "wk_ls");
        expect_at(1, S_RDY, 6'h00, "wk_rdy0");
        expect_at(1, S_AG,  6'h01, "wk_ag1");
        expect_at(2, S_RDY, 6'h04, "wk_rdy");
        expect_at(2, S_AG,  6'h00, "wk_ag0");
        expect_at(2, S_CLK, 6'h00, "wk_clk0");
        expect_at(3, S_CLK, 6'h04, "wk_clk");
        tick(3);

        // activity pulse during HOLD keeps ch2 clocked, counter reloads
        ch_active = 6'h00;
        expect_at(1, S_RDY, 6'h04, "hp_hold_rdy");
        expect_at(1, S_CLK, 6'h04, "hp_hold_clk");
        tick();
        ch_active = 6'h04;
        expect_at(1, S_RDY, 6'h04, "hp_run_rdy");
        expect_at(1, S_CLK, 6'h04, "hp_run_clk");
        tick();
        ch_active = 6'h00;
        expect_at(1, S_RDY, 6'h04, "hp_h1_rdy");
        expect_at(1, S_CLK, 6'h04, "hp_h1_clk");
        expect_at(2, S_RDY, 6'h04, "hp_h0_rdy");
        expect_at(2, S_CLK, 6'h04, "hp_h0_clk");
        expect_at(3, S_RDY, 6'h00, "hp_slp_rdy");
        expect_at(3, S_LS,  6'h3F, "hp_slp_ls");
        expect_at(3, S_CLK, 6'h04, "hp_slp_clklag");
        expect_at(4, S_CLK, 6'h00, "hp_slp_clk");
        expect_at(4, S_AG,  6'h01, "hp_slp_ag");
        tick(4);

        // cgstop override from all-SLEEP
        core_cgstop = 1'b1;
        expect_at(0, S_RDY, 6'h3F, "cgs_rdy_now");
        expect_at(0, S_LS,  6'h00, "cgs_ls_now");
        settle();
        expect_at(1, S_RDY, 6'h3F, "cgs_rdy");
        expect_at(1, S_CLK, 6'h3F, "cgs_clk");
        expect_at(1, S_AG,  6'h01, "cgs_ag_lag");
        tick();
        core_cgstop = 1'b0;
        expect_at(1, S_RDY, 6'h3F, "cgs_hold_rdy");
        expect_at(1, S_AG,  6'h00, "cgs_ag0");
        expect_at(2, S_RDY, 6'h3F, "cgs_h0_rdy");
        expect_at(3, S_RDY, 6'h00, "cgs_slp_rdy");
        expect_at(3, S_LS,  6'h3F, "cgs_slp_ls");
        expect_at(4, S_AG,  6'h01, "cgs_slp_ag");
        tick(4);

        // WFI qualifier on ch0 only
        ch_active = 6'h03;
        expect_at(1, S_LS,  6'h3C, "wfi_wk_ls");
        expect_at(1, S_RDY, 6'h00, "wfi_wk_rdy0");
        expect_at(2, S_RDY, 6'h03, "wfi_run_rdy");
        tick(2);
        core_wfi = 1'b1;
        expect_at(2, S_RDY, 6'h03, "wfi_hold_rdy");
        expect_at(3, S_RDY, 6'h02, "wfi_gate_rdy");
        expect_at(3, S_LS,  6'h3D, "wfi_gate_ls");
        expect_at(4, S_CLK, 6'h02, "wfi_gate_clk");
        expect_at(4, S_AG,  6'h00, "wfi_ag");
        tick(4);
        core_wfi = 1'b0;
        expect_at(1, S_LS,  6'h3C, "wfi_rel_ls");
        expect_at(2, S_RDY, 6'h03, "wfi_rel_rdy");
        expect_at(3, S_CLK, 6'h03, "wfi_rel_clk");
        tick(3);

        // test_mode in SLEEP
        ch_active = 6'h00;
        expect_at(3, S_RDY, 6'h00, "tm_slp_rdy");
        expect_at(3, S_LS,  6'h3F, "tm_slp_ls");
        tick(3);
        test_mode = 1'b1;
        expect_at(1, S_CLK, 6'h3F, "tm_clk1");
        expect_at(1, S_LS,  6'h3F, "tm_ls1");
        expect_at(1, S_AG,  6'h01, "tm_ag");
        expect_at(2, S_CLK, 6'h3F, "tm_clk2");
        expect_at(2, S_RDY, 6'h00, "tm_rdy");
        tick(2);
        test_mode = 1'b0;
        expect_at(1, S_CLK, 6'h00, "tm_off_clk");
        tick();

        // reset asserted mid-WAKE
        ch_active = 6'h01;
        expect_at(1, S_LS,  6'h3E, "rw_wk_ls");
        expect_at(1, S_RDY, 6'h00, "rw_wk_rdy");
        expect_at(1, S_AG,  6'h01, "rw_ag1");
        tick();
        rst_n = 1'b0;
        expect_at(0, S_RDY, 6'h3F, "rw_rst_rdy");
        expect_at(0, S_LS,  6'h00, "rw_rst_ls");
        expect_at(0, S_AG,  6'h00, "rw_rst_ag");
        settle();
        ch_active = 6'h00;
        tick(2);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
